// File: rtl/ymem_row_reader_pkg.sv
// Shared types and constants for the Y-RAM row reader: FSM states, word and
// entry geometry, and default parameter values.
package ymem_row_reader_pkg;

    localparam int WORD_W    = 256;
    localparam int PTR_W     = 16;
    localparam int PTR_SLOTS = WORD_W / PTR_W;
    localparam int ADDR_W    = 10;

    localparam int COL_W     = 16;
    localparam int RE_W      = 24;
    localparam int IM_W      = 24;
    localparam int ENTRY_W   = COL_W + RE_W + IM_W;
    localparam int ENTRIES   = 4;

    localparam logic [15:0]       ROW_NONE      = 16'hFFFF;
    localparam logic [ADDR_W-1:0] PTR_BASE_DEF  = 10'h3C0;
    localparam int                MAX_WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PTR_WAIT,
        ST_STREAM,
        ST_WAIT_EX
    } state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [RE_W-1:0]  re;
        logic [IM_W-1:0]  im;
    } ymem_entry_t;

endpackage

// File: rtl/yptr_slot_sel.sv
// Picks one 16-bit row pointer out of a 256-bit pointer-table word; slot 0
// occupies the most significant 16 bits.
module yptr_slot_sel
    import ymem_row_reader_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        slot,
    output logic [PTR_W-1:0]  ptr
);

    logic [PTR_W-1:0] slots [PTR_SLOTS];

    for (genvar gi = 0; gi < PTR_SLOTS; gi++) begin : g_slot
        assign slots[gi] = word[WORD_W-1-PTR_W*gi -: PTR_W];
    end

    assign ptr = slots[slot];

endmodule

// File: rtl/ymem_row_reader.sv
// Fetches a row pointer from the Y-RAM pointer table, then streams the row's
// data words until an all-zero terminator or MAX_WORDS words.
module ymem_row_reader
    import ymem_row_reader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PTR_BASE  = PTR_BASE_DEF,
    parameter int                MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [15:0]       req_row,
    output logic              req_ready,
    input  logic              ex_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [WORD_W-1:0] ram_data,
    output logic              ymem_ready_next,
    output logic [WORD_W-1:0] ymem_data,
    output logic              ymem_data_valid,
    output logic              row_done,
    output logic              row_err
);

    localparam int            CW     = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_WORDS);
    localparam logic [CW-1:0] LAST_C = CW'(MAX_WORDS - 1);

    state_t            state_reg, state_next;
    logic [3:0]        slot_reg, slot_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CW-1:0]     issue_cnt_reg, issue_cnt_next;
    logic [CW-1:0]     ret_cnt_reg, ret_cnt_next;
    logic              pending_reg, pending_next;
    logic [WORD_W-1:0] data_reg, data_next;
    logic              valid_reg, done_reg, err_reg;
    logic              valid_next, done_next, err_next;

    logic [PTR_W-1:0]  ptr;
    logic              req_accept, word_zero, word_last, word_end;
    logic              data_issue, empty_done;

    yptr_slot_sel u_slot_sel (
        .word (ram_data),
        .slot (slot_reg),
        .ptr  (ptr)
    );

    // rst_n gating keeps the combinational read strobe quiet while in reset.
    assign req_accept = rst_n && (state_reg == ST_IDLE) && req_valid && (req_row != ROW_NONE);
    assign word_zero  = (ram_data == '0);
    assign word_last  = (ret_cnt_reg == LAST_C);
    assign word_end   = pending_reg && (word_zero || word_last);

    always_comb begin
        state_next     = state_reg;
        slot_next      = slot_reg;
        addr_next      = addr_reg;
        issue_cnt_next = issue_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        ram_addr       = '0;
        ram_rd_en      = 1'b0;
        data_issue     = 1'b0;
        empty_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_accept) begin
                    ram_addr   = PTR_BASE + ADDR_W'(req_row[15:4]);
                    ram_rd_en  = 1'b1;
                    slot_next  = req_row[3:0];
                    state_next = ST_PTR_WAIT;
                end
            end
            ST_PTR_WAIT: begin
                if (ptr == '0) begin
                    empty_done = 1'b1;
                    state_next = ST_WAIT_EX;
                end else begin
                    ram_addr       = ptr[ADDR_W-1:0];
                    ram_rd_en      = 1'b1;
                    data_issue     = 1'b1;
                    addr_next      = ptr[ADDR_W-1:0] + ADDR_W'(1);
                    issue_cnt_next = CW'(1);
                    ret_cnt_next   = '0;
                    state_next     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue_cnt_reg < MAX_C) begin
                    ram_addr       = addr_reg;
                    ram_rd_en      = 1'b1;
                    data_issue     = 1'b1;
                    addr_next      = addr_reg + ADDR_W'(1);
                    issue_cnt_next = issue_cnt_reg + CW'(1);
                end
                if (pending_reg) begin
                    ret_cnt_next = ret_cnt_reg + CW'(1);
                end
                if (word_end) begin
                    state_next = ST_WAIT_EX;
                end
            end
            ST_WAIT_EX: begin
                if (ex_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A read issued in the cycle the row ends is still performed by the RAM,
    // but its data is never tracked as pending.
    always_comb begin
        pending_next = data_issue && !word_end;
        valid_next   = pending_reg;
        data_next    = pending_reg ? ram_data : data_reg;
        done_next    = word_end || empty_done;
        err_next     = pending_reg && !word_zero && word_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            slot_reg      <= '0;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            pending_reg   <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            addr_reg      <= addr_next;
            issue_cnt_reg <= issue_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
            pending_reg   <= pending_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign req_ready       = (state_reg == ST_IDLE);
    assign ymem_ready_next = pending_reg;
    assign ymem_data       = data_reg;
    assign ymem_data_valid = valid_reg;
    assign row_done        = done_reg;
    assign row_err         = err_reg;

endmodule
